// File: rtl/csv_row_sequencer_pkg.sv
// Shared constants and state encoding for the CSV row sequencer.
package csv_pkg;

    localparam logic [7:0] CSV_COMMA  = 8'h2C;
    localparam logic [7:0] CSV_LF     = 8'h0A;
    localparam logic [7:0] CSV_DQUOTE = 8'h22;

    typedef enum logic [2:0] {IDLE, FIELD, SEP, EOL, OPENQ, CLOSEQ} csv_seq_state_e;

endpackage

// File: rtl/csv_row_sequencer_if.sv
// Column-producer and byte-sink handshake bundle; slave side is the sequencer.
interface csv_row_sequencer_if #(
    parameter int unsigned N_COLS = 4
);
    logic [N_COLS-1:0]   fld_valid;
    logic [N_COLS*8-1:0] fld_data;
    logic [N_COLS-1:0]   fld_last;
    logic [N_COLS-1:0]   fld_empty;
    logic [N_COLS-1:0]   fld_ready;
    logic                out_valid;
    logic [7:0]          out_data;
    logic                out_ready;

    modport master (
        output fld_valid, fld_data, fld_last, fld_empty, out_ready,
        input  fld_ready, out_valid, out_data
    );

    modport slave (
        input  fld_valid, fld_data, fld_last, fld_empty, out_ready,
        output fld_ready, out_valid, out_data
    );
endinterface

// File: rtl/csv_byte_reg.sv
// Single-entry valid/ready output register; loadable when empty or drained the same cycle.
module csv_byte_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       can_load_o
);
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    assign can_load_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/csv_row_sequencer.sv
// Serialises N column producers into one CSV byte stream, in column order, with ',' and LF.
// Define CSV_QUOTE_EN to wrap every field in double quotes and double embedded quotes.
module csv_row_sequencer
    import csv_pkg::*;
#(
    parameter int unsigned N_COLS    = 4,
    parameter int unsigned ROW_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    csv_row_sequencer_if.slave   bus,
    output logic [ROW_CNT_W-1:0] row_count,
    output logic                 busy
);
    localparam int unsigned    COL_W    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

    csv_seq_state_e        state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  eol_q, eol_d;
    logic [ROW_CNT_W-1:0]  row_count_q, row_count_d;
`ifdef CSV_QUOTE_EN
    logic                  dup_q, dup_d;
    logic                  dup_last_q, dup_last_d;
`endif

    logic                  can_load, ld, ld_eol;
    logic [7:0]            ld_data;
    logic                  out_valid;
    logic [7:0]            out_data;
    logic [N_COLS-1:0]     col_oh;
    logic                  cur_valid, cur_last, cur_empty;
    logic [7:0]            cur_data;

    csv_byte_reg u_byte_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ld),
        .load_data_i (ld_data),
        .out_ready_i (bus.out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .can_load_o  (can_load)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign row_count     = row_count_q;
    assign busy          = (state_q != IDLE) || out_valid;

    always_comb begin
        col_oh    = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_empty = 1'b0;
        cur_data  = 8'h00;
        for (int unsigned c = 0; c < N_COLS; c++) begin
            if (col_q == COL_W'(c)) begin
                col_oh[c] = 1'b1;
                cur_valid = bus.fld_valid[c];
                cur_last  = bus.fld_last[c];
                cur_empty = bus.fld_empty[c];
                cur_data  = bus.fld_data[c*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        ld            = 1'b0;
        ld_data       = 8'h00;
        ld_eol        = 1'b0;
        bus.fld_ready = '0;
`ifdef CSV_QUOTE_EN
        dup_d         = dup_q;
        dup_last_d    = dup_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.fld_valid[0]) begin
                    col_d = '0;
`ifdef CSV_QUOTE_EN
                    state_d = OPENQ;
`else
                    state_d = FIELD;
`endif
                end
            end
            FIELD: begin
`ifdef CSV_QUOTE_EN
                // Second copy of an embedded quote: producer is held off this cycle.
                if (dup_q) begin
                    if (can_load) begin
                        ld      = 1'b1;
                        ld_data = CSV_DQUOTE;
                        dup_d   = 1'b0;
                        if (dup_last_q) state_d = CLOSEQ;
                    end
                end else
`endif
                if (can_load) begin
                    bus.fld_ready = col_oh;
                    if (cur_valid) begin
                        if (!cur_empty) begin
                            ld      = 1'b1;
                            ld_data = cur_data;
                        end
`ifdef CSV_QUOTE_EN
                        if (!cur_empty && cur_data == CSV_DQUOTE) begin
                            dup_d      = 1'b1;
                            dup_last_d = cur_last;
                        end else if (cur_last || cur_empty) begin
                            state_d = CLOSEQ;
                        end
`else
                        // An empty beat always ends the field, even without fld_last.
                        if (cur_last || cur_empty) state_d = (col_q == LAST_COL) ? EOL : SEP;
`endif
                    end
                end
            end
            SEP: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = CSV_COMMA;
                    col_d   = col_q + COL_W'(1);
`ifdef CSV_QUOTE_EN
                    state_d = OPENQ;
`else
                    state_d = FIELD;
`endif
                end
            end
            EOL: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = CSV_LF;
                    ld_eol  = 1'b1;
                    col_d   = '0;
                    state_d = IDLE;
                end
            end
`ifdef CSV_QUOTE_EN
            OPENQ: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = CSV_DQUOTE;
                    state_d = FIELD;
                end
            end
            CLOSEQ: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_data = CSV_DQUOTE;
                    state_d = (col_q == LAST_COL) ? EOL : SEP;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // eol_q tags the byte in the output register as the row terminator.
    always_comb begin
        eol_d       = eol_q;
        row_count_d = row_count_q;
        if (ld) begin
            eol_d = ld_eol;
        end else if (out_valid && bus.out_ready) begin
            eol_d = 1'b0;
        end
        if (out_valid && bus.out_ready && eol_q) row_count_d = row_count_q + ROW_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            eol_q       <= 1'b0;
            row_count_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            eol_q       <= eol_d;
            row_count_q <= row_count_d;
        end
    end

`ifdef CSV_QUOTE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_q      <= 1'b0;
            dup_last_q <= 1'b0;
        end else begin
            dup_q      <= dup_d;
            dup_last_q <= dup_last_d;
        end
    end
`endif
endmodule

// File: tb/tb_csv_row_sequencer.sv
// Randomised bench for csv_row_sequencer: per-column beat queues feed the DUT, a byte-level
// model of the expected CSV stream is checked every cycle; a second N_COLS=1 instance checks wrap.
module tb_csv_row_sequencer;
    localparam int NC = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       empty;
    } beat_t;
    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csv_row_sequencer_if #(.N_COLS(NC)) bus_a ();
    csv_row_sequencer_if #(.N_COLS(1))  bus_b ();
    logic [15:0] rc_a;
    logic        busy_a;
    logic [1:0]  rc_b;
    logic        busy_b;

    csv_row_sequencer #(.N_COLS(NC), .ROW_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .row_count(rc_a), .busy(busy_a)
    );
    csv_row_sequencer #(.N_COLS(1), .ROW_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .row_count(rc_b), .busy(busy_b)
    );

    beat_t        colq [NC][$];
    logic [8:0]   exp_q [$];     // bit 8 marks the LF that completes a row
    int unsigned  hs_cyc [$];
    int           n_err = 0;
    int           n_chk = 0;
    int unsigned  cyc = 0;
    int unsigned  hs_total = 0;
    int unsigned  model_rows = 0;
    int unsigned  gap_pct = 0;
    int           ready_mode = 0;  // 0 always ready, 1 toggle, 2 random
    logic         hold_q = 1'b0;
    logic [7:0]   hold_data = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t rand_field();
        bq_t q;
        int unsigned n = $urandom_range(0, 3);
        for (int unsigned i = 0; i < n; i++)
            q.push_back(($urandom_range(0, 5) == 0) ? 8'h22 : 8'($urandom_range(32, 126)));
        return q;
    endfunction

    // Expected CSV bytes for one field, followed by ',' or LF.
    task automatic add_field(input int c, input bq_t b);
        if (b.size() == 0)
            colq[c].push_back(beat_t'{data: 8'h00, last: 1'($urandom_range(0, 1)), empty: 1'b1});
        for (int i = 0; i < b.size(); i++)
            colq[c].push_back(beat_t'{data: b[i], last: (i == b.size() - 1), empty: 1'b0});
`ifdef CSV_QUOTE_EN
        exp_q.push_back({1'b0, 8'h22});
`endif
        for (int i = 0; i < b.size(); i++) begin
            exp_q.push_back({1'b0, b[i]});
`ifdef CSV_QUOTE_EN
            if (b[i] == 8'h22) exp_q.push_back({1'b0, 8'h22});
`endif
        end
`ifdef CSV_QUOTE_EN
        exp_q.push_back({1'b0, 8'h22});
`endif
        if (c == NC - 1) exp_q.push_back({1'b1, 8'h0A});
        else exp_q.push_back({1'b0, 8'h2C});
    endtask

    task automatic add_row_s(input string f0, input string f1, input string f2);
        add_field(0, s2q(f0));
        add_field(1, s2q(f1));
        add_field(2, s2q(f2));
    endtask

    task automatic pin_model(input string name, input string lit);
        logic ok;
        ok = (exp_q.size() == lit.len());
        for (int i = 0; ok && i < lit.len(); i++) if (exp_q[i][7:0] != lit[i]) ok = 1'b0;
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic compare_a();
        logic [8:0] e;
        check("row_count", 32'(rc_a), 32'(model_rows[15:0]));
        check("ready_onehot", 32'($countones(bus_a.fld_ready) <= 1), 32'd1);
        if (hold_q) begin
            check("hold_valid", 32'(bus_a.out_valid), 32'd1);
            check("hold_data", 32'(bus_a.out_data), 32'(hold_data));
        end
        if (bus_a.out_valid) check("busy", 32'(busy_a), 32'd1);
        if (bus_a.out_valid && bus_a.out_ready) begin
            hs_total++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL extra_byte: got 0x%02h, expected no byte", bus_a.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus_a.out_data), 32'(e[7:0]));
                if (e[8]) model_rows++;
            end
        end
        hold_q    = bus_a.out_valid && !bus_a.out_ready;
        hold_data = bus_a.out_data;
    endtask

    task automatic drive_a();
        for (int c = 0; c < NC; c++) begin
            if (colq[c].size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
                bus_a.fld_valid[c]      = 1'b1;
                bus_a.fld_data[c*8 +: 8] = colq[c][0].data;
                bus_a.fld_last[c]       = colq[c][0].last;
                bus_a.fld_empty[c]      = colq[c][0].empty;
            end else begin
                bus_a.fld_valid[c]      = 1'b0;
                bus_a.fld_data[c*8 +: 8] = 8'($urandom);
                bus_a.fld_last[c]       = 1'($urandom_range(0, 1));
                bus_a.fld_empty[c]      = 1'b0;
            end
        end
        case (ready_mode)
            0:       bus_a.out_ready = 1'b1;
            1:       bus_a.out_ready = !bus_a.out_ready;
            default: bus_a.out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step_a();
        logic [NC-1:0] acc;
        beat_t         b;
        @(negedge clk);
        compare_a();
        acc = bus_a.fld_valid & bus_a.fld_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NC; c++) if (acc[c] && colq[c].size() != 0) b = colq[c].pop_front();
        drive_a();
    endtask

    function automatic logic all_drained();
        logic d = (exp_q.size() == 0) && !busy_a;
        for (int c = 0; c < NC; c++) if (colq[c].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic run_a(input string name, input int unsigned budget);
        int unsigned start = cyc;
        drive_a();
        while (!all_drained() && (cyc - start) < budget) step_a();
        check({name, "_drained"}, 32'(all_drained()), 32'd1);
    endtask

    initial begin
        int unsigned nlf;
        int unsigned rows_b;
        int          idx;
        logic [7:0]  pat [$];

        rst = 1'b1;
        bus_a.fld_valid = '0; bus_a.fld_data = '0; bus_a.fld_last = '0;
        bus_a.fld_empty = '0; bus_a.out_ready = 1'b0;
        bus_b.fld_valid = '0; bus_b.fld_data = '0; bus_b.fld_last = '0;
        bus_b.fld_empty = '0; bus_b.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_data", 32'(bus_a.out_data), 32'd0);
        check("rst_fld_ready", 32'(bus_a.fld_ready), 32'd0);
        check("rst_row_count", 32'(rc_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_b_row_count", 32'(rc_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic row at full rate.
        hs_cyc.delete();
        add_row_s("ab", "c", "xyz");
`ifdef CSV_QUOTE_EN
        pin_model("model_row1", "\"ab\",\"c\",\"xyz\"\n");
`else
        pin_model("model_row1", "ab,c,xyz\n");
`endif
        idx = exp_q.size();
        run_a("row1", 200);
        check("row1_bytes", 32'(hs_cyc.size()), 32'(idx));
        if (hs_cyc.size() != 0) check("row1_back_to_back", hs_cyc[$] - hs_cyc[0], 32'(idx - 1));
        check("row1_count", 32'(rc_a), 32'd1);

        // Empty middle field, then embedded quote.
        hs_cyc.delete();
        add_row_s("ab", "", "xyz");
`ifdef CSV_QUOTE_EN
        pin_model("model_row2", "\"ab\",\"\",\"xyz\"\n");
`else
        pin_model("model_row2", "ab,,xyz\n");
`endif
        idx = exp_q.size();
        run_a("row2", 200);
        check("row2_bytes", 32'(hs_cyc.size()), 32'(idx));
        add_row_s("a\"b", "", "x");
`ifdef CSV_QUOTE_EN
        pin_model("model_row3", "\"a\"\"b\",\"\",\"x\"\n");
`else
        pin_model("model_row3", "a\"b,,x\n");
`endif
        run_a("row3", 200);
        check("row3_count", 32'(rc_a), 32'd3);

        // Back-pressure toggling plus producer gaps, then fully random rows.
        ready_mode = 1;
        gap_pct = 30;
        repeat (3) add_row_s("ab", "c", "xyz");
        run_a("toggle", 1000);
        ready_mode = 2;
        for (int r = 0; r < 25; r++) begin
            add_field(0, rand_field());
            add_field(1, rand_field());
            add_field(2, rand_field());
        end
        run_a("random", 8000);
        check("random_rows", 32'(rc_a), 32'd31);

        // Reset in the middle of a row.
        ready_mode = 0;
        gap_pct = 0;
        hs_total = 0;
        add_row_s("ab", "c", "xyz");
        drive_a();
        for (int i = 0; i < 50 && hs_total < 3; i++) step_a();
        check("pre_reset_bytes", 32'(hs_total), 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus_a.out_data), 32'd0);
        check("mid_rst_row_count", 32'(rc_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_fld_ready", 32'(bus_a.fld_ready), 32'd0);
        for (int c = 0; c < NC; c++) colq[c].delete();
        exp_q.delete();
        model_rows = 0;
        hold_q = 1'b0;
        bus_a.fld_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        add_row_s("ab", "c", "xyz");
        run_a("post_reset", 200);
        check("post_reset_count", 32'(rc_a), 32'd1);

        // Single-column instance: counter wraps at 2 bits.
`ifdef CSV_QUOTE_EN
        pat = '{8'h22, 8'h7A, 8'h22, 8'h0A};
`else
        pat = '{8'h7A, 8'h0A};
`endif
        bus_b.fld_valid = 1'b1;
        bus_b.fld_data  = 8'h7A;
        bus_b.fld_last  = 1'b1;
        bus_b.fld_empty = 1'b0;
        bus_b.out_ready = 1'b1;
        nlf = 0;
        rows_b = 0;
        idx = 0;
        for (int i = 0; i < 400 && nlf < 5; i++) begin
            @(negedge clk);
            check("b_row_count", 32'(rc_b), 32'(rows_b));
            if (bus_b.out_valid && bus_b.out_ready) begin
                check("b_byte", 32'(bus_b.out_data), 32'(pat[idx]));
                if (pat[idx] == 8'h0A) begin
                    rows_b = (rows_b + 1) % 4;
                    nlf++;
                end
                idx = (idx + 1) % pat.size();
            end
            @(posedge clk);
            #1;
            bus_b.out_ready = 1'($urandom_range(0, 1));
        end
        bus_b.fld_valid = 1'b0;
        bus_b.out_ready = 1'b1;
        check("b_rows_seen", 32'(nlf), 32'd5);
        @(negedge clk);
        check("b_wrap_final", 32'(rc_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
